// File: rtl/lsu_mem_master_if.sv
// Core request/response channel and data-memory channel of the load/store initiator.
// master = the initiator itself; slave = the core + memory environment around it.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_store_data;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_fault;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;

  modport master (
    input  req_valid, req_is_store, req_funct3, req_addr, req_store_data, mem_read_data,
    output req_ready, resp_valid, resp_data, resp_fault,
           mem_address, mem_write_data, mem_write, mem_read
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_addr, req_store_data, mem_read_data,
    input  req_ready, resp_valid, resp_data, resp_fault,
           mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_mem_master.sv
// RV64 load/store initiator: one request at a time against a 64-bit word-indexed memory,
// read-modify-write for sub-word stores, sign/zero extension for loads.
//
// state | meaning
// IDLE  | ready; accept request, detect faults
// RD    | read addressed doubleword (load data or RMW old value)
// WR    | write doubleword (full sd or merged sub-word)
// RESP  | one-cycle response pulse
module lsu_mem_master #(
  parameter int MEM_DEPTH = 256
) (
  input logic              clk,
  input logic              reset,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [2:0]  lane_q;
  logic [63:0] store_data_q;
  logic [63:0] mem_address_q;
  logic [63:0] mem_write_data_q;
  logic [63:0] resp_data_q;
  logic        resp_fault_q;

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic        is_sd;
  logic [5:0]  shamt;
  logic [63:0] rd_shifted;
  logic [63:0] load_ext;
  logic [63:0] size_mask;
  logic [63:0] merged;

  // Fault decode works on the live request so a bad access never leaves IDLE toward memory.
  always_comb begin
    illegal = bus.req_is_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      2'b11:   misaligned = (bus.req_addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
    out_of_range = (bus.req_addr >> 3) >= 64'(MEM_DEPTH);
    fault        = illegal | misaligned | out_of_range;
    is_sd        = bus.req_is_store && (bus.req_funct3[1:0] == 2'b11);
  end

  always_comb begin
    shamt      = {lane_q, 3'b000};
    rd_shifted = bus.mem_read_data >> shamt;
    case (funct3_q)
      3'b000:  load_ext = {{56{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  load_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      3'b100:  load_ext = {56'd0, rd_shifted[7:0]};
      3'b101:  load_ext = {48'd0, rd_shifted[15:0]};
      3'b110:  load_ext = {32'd0, rd_shifted[31:0]};
      default: load_ext = rd_shifted;
    endcase
    case (funct3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    merged = (bus.mem_read_data & ~(size_mask << shamt)) | ((store_data_q & size_mask) << shamt);
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (fault)      state_d = RESP;
          else if (is_sd) state_d = WR;
          else            state_d = RD;
        end
      end
      RD: begin
        bus.mem_read = 1'b1;
        state_d      = is_store_q ? WR : RESP;
      end
      WR: begin
        bus.mem_write = 1'b1;
        state_d       = RESP;
      end
      default: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Response fields change only on entry to RESP so they hold between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q       <= 1'b0;
      funct3_q         <= 3'b000;
      lane_q           <= 3'b000;
      store_data_q     <= 64'd0;
      mem_address_q    <= 64'd0;
      mem_write_data_q <= 64'd0;
      resp_data_q      <= 64'd0;
      resp_fault_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q   <= bus.req_is_store;
            funct3_q     <= bus.req_funct3;
            lane_q       <= bus.req_addr[2:0];
            store_data_q <= bus.req_store_data;
            if (fault) begin
              resp_data_q  <= 64'd0;
              resp_fault_q <= 1'b1;
            end else begin
              mem_address_q <= bus.req_addr >> 3;
              if (is_sd) mem_write_data_q <= bus.req_store_data;
            end
          end
        end
        RD: begin
          if (is_store_q) begin
            mem_write_data_q <= merged;
          end else begin
            resp_data_q  <= load_ext;
            resp_fault_q <= 1'b0;
          end
        end
        WR: begin
          resp_data_q  <= 64'd0;
          resp_fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_fault     = resp_fault_q;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the core's execute stage and the 64-bit word-indexed data memory.
- Memory side: `mem_read` / `mem_write` / `mem_address` / `mem_write_data`, with `mem_read_data` returned combinationally.
- Accepts one RV64 load or store at a time and handles byte, half, word and doubleword sizes.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Misaligned, illegal and out-of-range accesses are flagged and never reach memory.

Parameters:
- MEM_DEPTH, 256, number of 64-bit words in data memory; word index >= MEM_DEPTH is a fault.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block is idle and can accept a request.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV64 funct3 selecting size and extension.
- req_addr  input  64  byte address.
- req_store_data  input  64  store data; low bytes used for sub-word stores.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_data  output  64  extended load result; 0 for stores and faults.
- resp_fault  output  1  valid with resp_valid: misaligned, illegal funct3 or out of range.
- mem_address  output  64  word index, equal to req_addr >> 3.
- mem_write_data  output  64  merged doubleword to write.
- mem_write  output  1  memory write enable; memory writes on the clk edge ending the cycle.
- mem_read  output  1  memory read enable.
- mem_read_data  input  64  combinational read data from memory.

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_data=0, resp_fault=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Accept: in IDLE when req_valid && req_ready; latch is_store, funct3, addr, store_data. req_ready=1 only in IDLE.
- Size and extension, load funct3:
  - 000 lb, 001 lh, 010 lw, 011 ld: sign-extend.
  - 100 lbu, 101 lhu, 110 lwu: zero-extend.
  - 111: illegal.
- Store funct3: 000 sb, 001 sh, 010 sw, 011 sd; 1xx illegal.
- Alignment: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0.
- Byte lane = addr[2:0], little-endian; the lane never crosses a doubleword after the alignment check.
- Fault condition: misaligned, illegal funct3, or (addr>>3) >= MEM_DEPTH.
  - Evaluated at accept; transition IDLE->RESP.
  - resp_fault=1, resp_data=0, mem_read and mem_write stay 0 throughout.
- Load path: IDLE->RD->RESP.
  - In RD: mem_read=1, mem_address=addr>>3; sample mem_read_data at end of RD.
  - In RESP: resp_valid=1, resp_data = selected lane, extended.
- Store sd: IDLE->WR->RESP.
  - In WR: mem_write=1, mem_write_data=store_data.
- Store sb/sh/sw: IDLE->RD->WR->RESP.
  - RD: read the old doubleword.
  - WR: write the old doubleword with the addressed lane replaced by the low 8/16/32 bits of store_data.
  - RESP: resp_data=0.
- Latency, accept edge to resp_valid high:
  - Load and sd: 2 cycles.
  - Sub-word store: 3 cycles.
  - Fault: 1 cycle.
- Throughput: RESP->IDLE unconditionally, so the next accept happens one cycle after RESP; there is no response backpressure.
- Output timing and hold:
  - mem_read and mem_write are never both 1; both are 0 in IDLE and RESP.
  - mem_address and mem_write_data hold their last values outside RD/WR.
  - resp_valid is high for exactly one cycle; resp_data and resp_fault hold until the next RESP.
- req_valid while busy: ignored; the request must be held by the core until accepted.
- Reset mid-operation: the state returns to IDLE at that edge.
  - Reset in RD: no write ever occurs.
  - Reset in WR: mem_write is deasserted; the write completing on the reset edge is permitted and is the only memory side effect.
  - No resp_valid for the aborted request.

Test Plan:
- Memory word i preloaded with i; ld addr=0x18 accepted at cycle N.
  -> mem_read=1, mem_address=3 in N+1.
  -> resp_valid at N+2, resp_data=0x3, resp_fault=0.
- sb addr=0x21 data=0xAB.
  -> RD then WR; mem_write_data=0x000000000000AB04 into word 4.
  -> resp_valid at accept+3.
  -> then lbu 0x21 returns 0xAB; lb 0x21 returns 0xFFFFFFFFFFFFFFAB.
- sh addr=0x2E data=0x8001 into word 5.
  -> word5=0x8001000000000005.
  -> lh 0x2E returns 0xFFFFFFFFFFFF8001; lhu 0x2E returns 0x8001.
- lw addr=0x22, then sd addr=0x0C, then store funct3=100, then ld addr=0x800 (word 256).
  -> each gives resp_fault=1 one cycle after accept.
  -> resp_data=0; mem_read and mem_write never asserted.
- req_valid held high with three back-to-back loads.
  -> req_ready low in RD/RESP; accepts every 3 cycles; responses in order.
- reset asserted during RD of sh 0x10.
  -> next cycle state IDLE, req_ready=1, no resp_valid.
  -> word 2 still 0x2.
